// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
// Holds the capture FSM state encoding and the default counter width. The
// generator's RESOLUTION uses the same width.
package pwm_pkg;

  localparam int PWM_CNT_WIDTH = 16;

  typedef enum logic {
    WAIT_RISE = 1'b0,
    MEASURE   = 1'b1
  } cap_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Input conditioning for pwm_capture.
// Brings the asynchronous PWM line into the clk domain and, in builds that
// define PWM_CAP_GLITCH_FILT_EN, filters short pulses. It then produces
// registered one-cycle rise/fall strobes and the accepted line level.
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
`ifdef PWM_CAP_GLITCH_FILT_EN
  , parameter int GLITCH_CYCLES = 3
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_raw;
  logic                   s;
  logic                   s_d;

  // Metastability chain: pwm_in shifts in at bit 0, the synced level leaves the top bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign s_raw = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAP_GLITCH_FILT_EN
  localparam int GW = (GLITCH_CYCLES < 1) ? 1 : $clog2(GLITCH_CYCLES + 1);

  logic [GW-1:0] diff_cnt;
  logic          filt_q;

  // Accept a new level only after it has disagreed with the current one for GLITCH_CYCLES cycles in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q   <= 1'b0;
      diff_cnt <= '0;
    end else if (s_raw == filt_q) begin
      diff_cnt <= '0;
    end else if (diff_cnt >= GW'(GLITCH_CYCLES - 1)) begin
      filt_q   <= s_raw;
      diff_cnt <= '0;
    end else begin
      diff_cnt <= diff_cnt + GW'(1);
    end
  end

  assign s = filt_q;
`else
  assign s = s_raw;
`endif

  // Edge detector: strobes are registered so both edges carry identical latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s_d  <= s;
      rise <= s & ~s_d;
      fall <= ~s & s_d;
    end
  end

  // s_d is aligned with the rise/fall strobes, so the reported level never leads an edge
  assign level = s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of one PWM line.
// A measurement is reported on every rise except the first one after reset
// or after a stuck-line timeout, because that period is incomplete.
// Optional build macro: PWM_CAP_GLITCH_FILT_EN adds a pulse filter after the
// synchronizer. It delays both edges equally, so measured values are unchanged.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH     = PWM_CNT_WIDTH,
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] high_cnt,
  output logic [CNT_WIDTH-1:0] period_cnt,
  output logic                 meas_valid,
  output logic                 timeout,
  output logic                 pwm_level
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Supported range: CNT_WIDTH >= 4, SYNC_STAGES >= 2, GLITCH_CYCLES >= 1.
  if (CNT_WIDTH < 4 || SYNC_STAGES < 2 || GLITCH_CYCLES < 1) begin : g_unsupported_cfg
  end

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic                 rise;
  logic                 fall;
  cap_state_t           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] hi_shadow;

  pwm_edge_sync #(
    .SYNC_STAGES   (SYNC_STAGES)
`ifdef PWM_CAP_GLITCH_FILT_EN
    , .GLITCH_CYCLES (GLITCH_CYCLES)
`endif
  ) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .rise   (rise),
    .fall   (fall),
    .level  (pwm_level)
  );

  // Measurement FSM with run counter, high-time shadow and published results.
  // cnt counts cycles since the last rise, so on an edge cnt+1 is the elapsed length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_RISE;
      cnt        <= '0;
      hi_shadow  <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      cnt        <= sat_inc(cnt);
      if (rise) begin
        // A rise wins over saturation in the same cycle
        cnt   <= '0;
        state <= MEASURE;
        if (state == MEASURE) begin
          period_cnt <= sat_inc(cnt);
          high_cnt   <= hi_shadow;
          meas_valid <= 1'b1;
          timeout    <= 1'b0;
        end
      end else begin
        if (fall && state == MEASURE) hi_shadow <= sat_inc(cnt);
        if (cnt == CNT_MAX) begin
          // Line stuck: drop the partial period and resync on the next rise
          timeout <= 1'b1;
          state   <= WAIT_RISE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture (CNT_WIDTH=8 so the stuck-line timeout is reachable).
module tb_pwm_capture;

  localparam int CW = 8;
  localparam int SS = 2;
  localparam int GC = 3;
`ifdef PWM_CAP_GLITCH_FILT_EN
  localparam int LAT = SS + GC + 2;
`else
  localparam int LAT = SS + 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] period_cnt;
  logic          meas_valid;
  logic          timeout;
  logic          pwm_level;

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;

  int rise_log[$];
  int st_cyc[$];
  int st_hi[$];
  int st_per[$];

  pwm_capture #(
    .CNT_WIDTH     (CW),
    .SYNC_STAGES   (SS),
    .GLITCH_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .pwm_level  (pwm_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe logger, sampled on the falling edge
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      st_cyc.push_back(cyc);
      st_hi.push_back(int'(high_cnt));
      st_per.push_back(int'(period_cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v);
    step();
    if (v && !pwm_in) rise_log.push_back(cyc);
    pwm_in = v;
  endtask

  task automatic run_wave(input int hi, input int per, input int n);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < per; i++)
        drive(i < hi);
  endtask

  task automatic clear_logs();
    rise_log.delete();
    st_cyc.delete();
    st_hi.delete();
    st_per.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    #1;
    n_checks++; if (high_cnt !== 8'd0) $display("FAIL reset_high_cnt: got %0d expected 0", high_cnt); else n_pass++;
    n_checks++; if (period_cnt !== 8'd0) $display("FAIL reset_period_cnt: got %0d expected 0", period_cnt); else n_pass++;
    n_checks++; if (meas_valid !== 1'b0) $display("FAIL reset_meas_valid: got %b expected 0", meas_valid); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", timeout); else n_pass++;
    n_checks++; if (pwm_level !== 1'b0) $display("FAIL reset_pwm_level: got %b expected 0", pwm_level); else n_pass++;
    repeat (4) drive(1'b0);
    n_checks++; if (meas_valid !== 1'b0) $display("FAIL idle_meas_valid: got %b expected 0", meas_valid); else n_pass++;
  endtask

  task automatic test_steady();
    clear_logs();
    run_wave(25, 100, 5);
    n_checks++; if (st_cyc.size() != 4) $display("FAIL steady_strobe_count: got %0d expected 4", st_cyc.size()); else n_pass++;
    for (int k = 0; k < 4 && k < st_cyc.size(); k++) begin
      n_checks++; if (st_cyc[k] != rise_log[k+1] + LAT) $display("FAIL steady_latency[%0d]: got cycle %0d expected %0d", k, st_cyc[k], rise_log[k+1] + LAT); else n_pass++;
      n_checks++; if (st_hi[k] != 25) $display("FAIL steady_high[%0d]: got %0d expected 25", k, st_hi[k]); else n_pass++;
      n_checks++; if (st_per[k] != 100) $display("FAIL steady_period[%0d]: got %0d expected 100", k, st_per[k]); else n_pass++;
    end
  endtask

  task automatic test_duty_change();
    int exp_hi[3];
    exp_hi = '{25, 60, 60};
    clear_logs();
    run_wave(60, 100, 3);
    n_checks++; if (st_cyc.size() != 3) $display("FAIL duty_strobe_count: got %0d expected 3", st_cyc.size()); else n_pass++;
    for (int k = 0; k < 3 && k < st_cyc.size(); k++) begin
      n_checks++; if (st_cyc[k] != rise_log[k] + LAT) $display("FAIL duty_latency[%0d]: got cycle %0d expected %0d", k, st_cyc[k], rise_log[k] + LAT); else n_pass++;
      n_checks++; if (st_hi[k] != exp_hi[k]) $display("FAIL duty_high[%0d]: got %0d expected %0d", k, st_hi[k], exp_hi[k]); else n_pass++;
      n_checks++; if (st_per[k] != 100) $display("FAIL duty_period[%0d]: got %0d expected 100", k, st_per[k]); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    repeat (200) drive(1'b1);
    n_checks++; if (timeout !== 1'b0) $display("FAIL stuck_early_timeout: got %b expected 0", timeout); else n_pass++;
    repeat (100) drive(1'b1);
    n_checks++; if (timeout !== 1'b1) $display("FAIL stuck_timeout: got %b expected 1", timeout); else n_pass++;
    n_checks++; if (pwm_level !== 1'b1) $display("FAIL stuck_level: got %b expected 1", pwm_level); else n_pass++;
    n_checks++; if (high_cnt !== 8'd60) $display("FAIL stuck_hold_high: got %0d expected 60", high_cnt); else n_pass++;
    n_checks++; if (period_cnt !== 8'd100) $display("FAIL stuck_hold_period: got %0d expected 100", period_cnt); else n_pass++;
    clear_logs();
    repeat (8) drive(1'b0);
    n_checks++; if (timeout !== 1'b1) $display("FAIL resume_timeout_held: got %b expected 1", timeout); else n_pass++;
    n_checks++; if (pwm_level !== 1'b0) $display("FAIL resume_level: got %b expected 0", pwm_level); else n_pass++;
    run_wave(4, 10, 3);
    n_checks++; if (st_cyc.size() != 2) $display("FAIL resume_strobe_count: got %0d expected 2", st_cyc.size()); else n_pass++;
    if (st_cyc.size() > 0) begin
      n_checks++; if (st_cyc[0] != rise_log[1] + LAT) $display("FAIL resume_first_strobe: got cycle %0d expected %0d", st_cyc[0], rise_log[1] + LAT); else n_pass++;
      n_checks++; if (st_hi[0] != 4) $display("FAIL resume_high: got %0d expected 4", st_hi[0]); else n_pass++;
      n_checks++; if (st_per[0] != 10) $display("FAIL resume_period: got %0d expected 10", st_per[0]); else n_pass++;
    end
    n_checks++; if (timeout !== 1'b0) $display("FAIL resume_timeout_clear: got %b expected 0", timeout); else n_pass++;
  endtask

  task automatic test_glitch();
`ifdef PWM_CAP_GLITCH_FILT_EN
    int exp_n = 2, exp_hi = 40, exp_per = 100, rise_idx = 2;
`else
    int exp_n = 3, exp_hi = 20, exp_per = 21, rise_idx = 1;
`endif
    clear_logs();
    for (int i = 0; i < 100; i++) drive(i < 40 && i != 20);
    run_wave(40, 100, 1);
    n_checks++; if (st_cyc.size() != exp_n) $display("FAIL glitch_strobe_count: got %0d expected %0d", st_cyc.size(), exp_n); else n_pass++;
    if (st_cyc.size() > 1) begin
      n_checks++; if (st_hi[0] != 4 || st_per[0] != 10) $display("FAIL glitch_prev_period: got %0d/%0d expected 4/10", st_hi[0], st_per[0]); else n_pass++;
      n_checks++; if (st_cyc[1] != rise_log[rise_idx] + LAT) $display("FAIL glitch_latency: got cycle %0d expected %0d", st_cyc[1], rise_log[rise_idx] + LAT); else n_pass++;
      n_checks++; if (st_hi[1] != exp_hi) $display("FAIL glitch_high: got %0d expected %0d", st_hi[1], exp_hi); else n_pass++;
      n_checks++; if (st_per[1] != exp_per) $display("FAIL glitch_period: got %0d expected %0d", st_per[1], exp_per); else n_pass++;
    end
  endtask

`ifndef PWM_CAP_GLITCH_FILT_EN
  task automatic test_min_period();
    clear_logs();
    run_wave(1, 2, 10);
    repeat (6) drive(1'b0);
    n_checks++; if (st_cyc.size() != 10) $display("FAIL minp_strobe_count: got %0d expected 10", st_cyc.size()); else n_pass++;
    for (int k = 1; k < 10 && k < st_cyc.size(); k++) begin
      n_checks++; if (st_cyc[k] != rise_log[k] + LAT) $display("FAIL minp_latency[%0d]: got cycle %0d expected %0d", k, st_cyc[k], rise_log[k] + LAT); else n_pass++;
      n_checks++; if (st_hi[k] != 1 || st_per[k] != 2) $display("FAIL minp_value[%0d]: got %0d/%0d expected 1/2", k, st_hi[k], st_per[k]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int a = 0, c = 0, seen = 0, exp_cyc = -1, first = -1;
    clear_logs();
    for (int i = 0; i < 30; i++) begin
      drive(i % 2 == 0);
      if (i == 10) begin rst = 1'b1; a = cyc; end
      if (i == 11) begin
        n_checks++; if (meas_valid !== 1'b0 || high_cnt !== 8'd0 || period_cnt !== 8'd0)
          $display("FAIL midrst_outputs: got mv=%b hi=%0d per=%0d expected 0/0/0", meas_valid, high_cnt, period_cnt); else n_pass++;
      end
      if (i == 12) begin rst = 1'b0; c = cyc; end
    end
    repeat (6) drive(1'b0);
    foreach (rise_log[k]) if (rise_log[k] >= c) begin
      seen++;
      if (seen == 2) exp_cyc = rise_log[k] + LAT;
    end
    foreach (st_cyc[k]) if (first < 0 && st_cyc[k] >= a) first = k;
    n_checks++; if (first < 0) $display("FAIL midrst_no_strobe: got none expected cycle %0d", exp_cyc);
    else if (st_cyc[first] != exp_cyc) $display("FAIL midrst_first_strobe: got cycle %0d expected %0d", st_cyc[first], exp_cyc); else n_pass++;
    if (first >= 0) begin
      n_checks++; if (st_hi[first] != 1 || st_per[first] != 2) $display("FAIL midrst_value: got %0d/%0d expected 1/2", st_hi[first], st_per[first]); else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_steady();
    test_duty_change();
    test_timeout();
    test_glitch();
`ifndef PWM_CAP_GLITCH_FILT_EN
    test_min_period();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
